store_drain_unit: RTL and testbench
===================================

Name: store_drain_unit

Overview:
- Sits directly downstream of the store buffer. Consumes the buffer head's cache write request (address, value, size, wenable) and performs the write into the data-cache array.
- Handles cache misses by issuing a line-fill request to memory and retrying the write once the fill completes.
- Yields the single cache port to loads.
- Returns a one-cycle store_success pulse so the store buffer retires its head.

Parameters:
WORD_SIZE, `WORD_SIZE (32), data width in bits
WIDTH, `ADDRESS_WIDTH (32), physical address width
SIZE_WRITE_WIDTH, `SIZE_WRITE_WIDTH, store size encoding width
LINE_BYTES, 16, cache line size in bytes (power of 2, >= 4)
CNT_WIDTH, 32, width of the miss statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sb_wenable  in  1  store buffer head is permitted to write
sb_addr  in  WIDTH  head physical address
sb_value  in  WORD_SIZE  head store data
sb_size  in  SIZE_WRITE_WIDTH  `FULL_WORD_SIZE or `BYTE_SIZE
store_success  out  1  one-cycle pulse: head write done, buffer may pop
load_active  in  1  memory stage owns the cache port this cycle
cache_hit  in  1  combinational tag-hit for dc_addr
dc_addr  out  WIDTH  word-aligned cache address (valid from LOOKUP onward)
dc_wdata  out  WORD_SIZE  lane-aligned write data
dc_byte_mask  out  4  byte enables
dc_wenable  out  1  cache array write strobe
mem_req  out  1  line-fill request, held until mem_ack
mem_addr  out  WIDTH  line-aligned fill address
mem_ack  in  1  one-cycle pulse: fill installed in cache
align_error  out  1  one-cycle pulse: misaligned word store dropped
busy  out  1  state != IDLE
miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset: state=IDLE. Every output is 0: store_success, dc_*, mem_req, mem_addr, align_error, busy, miss_count. Latched request registers are cleared.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT.
- IDLE
  - Waits for sb_wenable=1 && load_active=0.
  - On that condition, latches addr/value/size and goes to LOOKUP.
  - Misaligned word store (size=FULL_WORD, addr[1:0]!=0): no latch, pulses align_error and store_success in the same cycle, stays IDLE. The store is dropped to avoid deadlock.
- LOOKUP
  - dc_addr = {addr[WIDTH-1:2],2'b00}.
  - If load_active=1: holds, no write.
  - Else if cache_hit: dc_wenable=1 and store_success=1 in this same cycle, then IDLE.
  - Else: miss_count increments (saturating at all-ones), then MISS_REQ.
- Lane mapping
  - FULL_WORD: mask=4'b1111, wdata=value.
  - BYTE: mask=1<<addr[1:0], wdata=value[7:0] replicated into all four lanes.
- MISS_REQ: mem_req=1, mem_addr = addr with low log2(LINE_BYTES) bits cleared. Next cycle goes to MISS_WAIT.
- MISS_WAIT
  - mem_req stays 1 until a cycle with mem_ack=1.
  - On mem_ack, mem_req drops next cycle and the FSM returns to LOOKUP to retry. The tag is rechecked, never assumed hit.
  - mem_ack in any other state is ignored.
- Latency:
  - Hit, no load conflict: 2 cycles from sb_wenable sampled to store_success.
  - Each load_active cycle in LOOKUP adds 1 cycle.
- Exactly one store in flight. sb_* inputs are ignored outside IDLE, and the latched copy is used.
- store_success pulses at most once per accepted store and is never asserted in two consecutive cycles.
  - Re-entry from IDLE requires sb_wenable, which reflects the new head only after the buffer pops.
- dc_wenable is never asserted in a cycle where load_active=1.
- Back-to-back hits: IDLE->LOOKUP->IDLE->LOOKUP, so a sustained throughput of 1 store per 2 cycles.
- Reset mid-miss: next cycle is IDLE with mem_req=0. A late mem_ack is ignored and miss_count is cleared.
- busy=1 in every state except IDLE.

Test Plan:
- Hit word store: sb_addr=0x100, value=0xDEADBEEF, FULL_WORD, cache_hit=1 -> cycle 2 dc_wenable=1, dc_addr=0x100, mask=1111, store_success single pulse.
- Byte store to 0x203, value=0x000000AB, hit -> dc_addr=0x200, mask=1000, dc_wdata=0xABABABAB.
- Load conflict: hold load_active=1 for 3 cycles while in LOOKUP -> no dc_wenable during them; write + store_success on the cycle load_active falls.
- Miss: addr 0x1234, cache_hit=0 -> mem_req=1 with mem_addr=0x1230 (LINE_BYTES=16) held until mem_ack 5 cycles later, miss_count=1; then cache_hit=1 -> write + store_success.
- Misaligned word store to 0x102 -> align_error and store_success pulse together, no dc_wenable, state stays IDLE.
- rst asserted during MISS_WAIT, then mem_ack pulsed -> mem_req=0, busy=0, miss_count=0, no store_success.

Source files
------------

// File: rtl/store_drain_unit.sv
// Store drain unit: writes the store-buffer head into the data cache, handles
// misses with a line-fill request, and yields the cache port to loads.
module store_drain_unit #(
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned SIZE_WRITE_WIDTH = 2,
    parameter int unsigned LINE_BYTES       = 16,
    parameter int unsigned CNT_WIDTH        = 32,
    parameter logic [SIZE_WRITE_WIDTH-1:0] FULL_WORD_SIZE = SIZE_WRITE_WIDTH'(2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sb_wenable,
    input  logic [WIDTH-1:0]            sb_addr,
    input  logic [WORD_SIZE-1:0]        sb_value,
    input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
    output logic                        store_success,
    input  logic                        load_active,
    input  logic                        cache_hit,
    output logic [WIDTH-1:0]            dc_addr,
    output logic [WORD_SIZE-1:0]        dc_wdata,
    output logic [3:0]                  dc_byte_mask,
    output logic                        dc_wenable,
    output logic                        mem_req,
    output logic [WIDTH-1:0]            mem_addr,
    input  logic                        mem_ack,
    output logic                        align_error,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        miss_count
);

    localparam logic [WIDTH-1:0] LINE_MASK = ~WIDTH'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] addr_q;
    logic             succ_q;

    logic accept_c;
    logic is_word_c;
    logic misaligned_c;
    logic drop_c;
    logic hit_c;

    // The cache hit and the misaligned drop must answer in the cycle they are
    // observed, so the write strobe and the retire pulse are decoded from state.
    assign accept_c     = (state == IDLE) && sb_wenable && !load_active;
    assign is_word_c    = (sb_size == FULL_WORD_SIZE);
    assign misaligned_c = is_word_c && (sb_addr[1:0] != 2'b00);
    // A drop right after a retire would give back-to-back store_success pulses.
    assign drop_c       = accept_c && misaligned_c && !succ_q;
    assign hit_c        = (state == LOOKUP) && !load_active && cache_hit;

    assign dc_wenable    = hit_c;
    assign store_success = hit_c || drop_c;
    assign align_error   = drop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            succ_q       <= 1'b0;
            dc_addr      <= '0;
            dc_wdata     <= '0;
            dc_byte_mask <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            miss_count   <= '0;
        end else begin
            succ_q <= store_success;
            case (state)
                IDLE: begin
                    if (accept_c && !misaligned_c) begin
                        addr_q  <= sb_addr;
                        dc_addr <= {sb_addr[WIDTH-1:2], 2'b00};
                        if (is_word_c) begin
                            dc_byte_mask <= 4'b1111;
                            dc_wdata     <= sb_value;
                        end else begin
                            dc_byte_mask <= 4'(4'b0001 << sb_addr[1:0]);
                            dc_wdata     <= WORD_SIZE'({4{sb_value[7:0]}});
                        end
                        state <= LOOKUP;
                        busy  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (!load_active) begin
                        if (cache_hit) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            if (miss_count != '1) begin
                                miss_count <= miss_count + CNT_WIDTH'(1);
                            end
                            mem_req  <= 1'b1;
                            mem_addr <= addr_q & LINE_MASK;
                            state    <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    // Retry the lookup after the fill; the tag is checked again.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= LOOKUP;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_drain_unit.sv
// Bench for store_drain_unit: directed protocol steps followed by random
// stores checked against a transaction-level model with a resident-line table.
module tb_store_drain_unit;

    localparam logic [1:0] FW = 2'd2;
    localparam logic [1:0] BY = 2'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        sb_wenable;
    logic [31:0] sb_addr;
    logic [31:0] sb_value;
    logic [1:0]  sb_size;
    logic        store_success;
    logic        load_active;
    logic        cache_hit;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_byte_mask;
    logic        dc_wenable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        align_error;
    logic        busy;
    logic [31:0] miss_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic hit_force_en;
    logic hit_force_val;
    logic resident [256];

    store_drain_unit #(
        .WORD_SIZE(32), .WIDTH(32), .SIZE_WRITE_WIDTH(2),
        .LINE_BYTES(16), .CNT_WIDTH(32), .FULL_WORD_SIZE(FW)
    ) dut (
        .clk(clk), .rst(rst),
        .sb_wenable(sb_wenable), .sb_addr(sb_addr), .sb_value(sb_value), .sb_size(sb_size),
        .store_success(store_success), .load_active(load_active), .cache_hit(cache_hit),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_byte_mask(dc_byte_mask),
        .dc_wenable(dc_wenable), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .align_error(align_error), .busy(busy), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        cache_hit = hit_force_en ? hit_force_val : resident[dc_addr[11:4]];
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop();
        next();
        sb_wenable = 1'b0;
        load_active = 1'b0;
        #1;
        chk("pop_success_low", 64'(store_success), 64'd0);
        chk("pop_busy", 64'(busy), 64'd0);
    endtask

    task automatic present(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
        sb_wenable = 1'b1;
        sb_addr    = a;
        sb_size    = sz;
        sb_value   = v;
    endtask

    // random-phase state
    logic [31:0] a, v, exp_da, exp_wd, exp_line;
    logic [3:0]  exp_mask;
    logic        word, mis, done, prev_ss, req_seen;
    int          ack_dly, writes, exp_miss;

    initial begin
        rst = 1'b1;
        sb_wenable = 1'b0; sb_addr = '0; sb_value = '0; sb_size = FW;
        load_active = 1'b0; mem_ack = 1'b0;
        hit_force_en = 1'b1; hit_force_val = 1'b0;
        for (int i = 0; i < 256; i++) resident[i] = 1'b0;
        next();
        next();
        rst = 1'b0;
        #1;
        chk("rst_success", 64'(store_success), 64'd0);
        chk("rst_dc_addr", 64'(dc_addr), 64'd0);
        chk("rst_dc_wdata", 64'(dc_wdata), 64'd0);
        chk("rst_dc_mask", 64'(dc_byte_mask), 64'd0);
        chk("rst_dc_wenable", 64'(dc_wenable), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_align", 64'(align_error), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);

        // hit word store
        next();
        present(32'h100, FW, 32'hDEADBEEF);
        hit_force_val = 1'b1;
        #1;
        chk("hw_c1_success", 64'(store_success), 64'd0);
        next();
        #1;
        chk("hw_wen", 64'(dc_wenable), 64'd1);
        chk("hw_addr", 64'(dc_addr), 64'h100);
        chk("hw_mask", 64'(dc_byte_mask), 64'hF);
        chk("hw_wdata", 64'(dc_wdata), 64'hDEADBEEF);
        chk("hw_success", 64'(store_success), 64'd1);
        chk("hw_busy", 64'(busy), 64'd1);
        pop();

        // hit byte store
        next();
        present(32'h203, BY, 32'h000000AB);
        #1;
        next();
        #1;
        chk("hb_wen", 64'(dc_wenable), 64'd1);
        chk("hb_addr", 64'(dc_addr), 64'h200);
        chk("hb_mask", 64'(dc_byte_mask), 64'h8);
        chk("hb_wdata", 64'(dc_wdata), 64'hABABABAB);
        chk("hb_success", 64'(store_success), 64'd1);
        pop();

        // load conflict in LOOKUP for 3 cycles
        next();
        present(32'h300, FW, 32'h11223344);
        #1;
        for (int k = 0; k < 3; k++) begin
            next();
            load_active = 1'b1;
            #1;
            chk("lc_hold_wen", 64'(dc_wenable), 64'd0);
            chk("lc_hold_success", 64'(store_success), 64'd0);
        end
        next();
        load_active = 1'b0;
        #1;
        chk("lc_wen", 64'(dc_wenable), 64'd1);
        chk("lc_success", 64'(store_success), 64'd1);
        chk("lc_wdata", 64'(dc_wdata), 64'h11223344);
        pop();

        // miss, fill acked 5 cycles after the request, then hit
        next();
        present(32'h1234, FW, 32'hCAFEF00D);
        hit_force_val = 1'b0;
        #1;
        next();
        #1;
        chk("ms_lookup_addr", 64'(dc_addr), 64'h1234);
        chk("ms_lookup_wen", 64'(dc_wenable), 64'd0);
        chk("ms_lookup_req", 64'(mem_req), 64'd0);
        next();
        #1;
        chk("ms_req", 64'(mem_req), 64'd1);
        chk("ms_mem_addr", 64'(mem_addr), 64'h1230);
        chk("ms_count", 64'(miss_count), 64'd1);
        chk("ms_busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            next();
            mem_ack = (k == 5);
            #1;
            chk("ms_req_held", 64'(mem_req), 64'd1);
            chk("ms_wait_success", 64'(store_success), 64'd0);
        end
        next();
        mem_ack = 1'b0;
        hit_force_val = 1'b1;
        #1;
        chk("ms_req_drop", 64'(mem_req), 64'd0);
        chk("ms_retry_wen", 64'(dc_wenable), 64'd1);
        chk("ms_retry_success", 64'(store_success), 64'd1);
        chk("ms_retry_addr", 64'(dc_addr), 64'h1234);
        pop();

        // misaligned word store is dropped
        next();
        present(32'h102, FW, 32'h55555555);
        #1;
        chk("mal_align", 64'(align_error), 64'd1);
        chk("mal_success", 64'(store_success), 64'd1);
        chk("mal_wen", 64'(dc_wenable), 64'd0);
        next();
        sb_wenable = 1'b0;
        #1;
        chk("mal_idle_busy", 64'(busy), 64'd0);
        chk("mal_align_low", 64'(align_error), 64'd0);
        chk("mal_success_low", 64'(store_success), 64'd0);

        // reset while waiting for a fill, then a late ack
        next();
        present(32'h500, FW, 32'h0BADF00D);
        hit_force_val = 1'b0;
        #1;
        next();
        next();
        next();
        #1;
        chk("rm_wait_req", 64'(mem_req), 64'd1);
        chk("rm_wait_count", 64'(miss_count), 64'd2);
        rst = 1'b1;
        sb_wenable = 1'b0;
        next();
        rst = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rm_req", 64'(mem_req), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_count", 64'(miss_count), 64'd0);
        chk("rm_success", 64'(store_success), 64'd0);
        next();
        mem_ack = 1'b0;
        #1;
        chk("rm_late_busy", 64'(busy), 64'd0);
        chk("rm_late_req", 64'(mem_req), 64'd0);

        // random stores against the resident-line model
        hit_force_en = 1'b0;
        exp_miss = 0;
        prev_ss = 1'b0;
        req_seen = 1'b0;
        ack_dly = 0;
        next();
        for (int i = 0; i < 150; i++) begin
            a = 32'($urandom_range(0, 4095));
            word = 1'($urandom_range(0, 1));
            if (word && $urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            v = $urandom;
            mis = word && (a[1:0] != 2'b00);
            exp_da = {a[31:2], 2'b00};
            exp_line = {a[31:4], 4'h0};
            exp_mask = word ? 4'hF : (4'h1 << a[1:0]);
            exp_wd = word ? v : {4{v[7:0]}};
            if (!mis && !resident[a[11:4]]) exp_miss++;
            writes = 0;
            done = 1'b0;
            present(a, word ? FW : BY, v);
            for (int c = 0; c < 300 && !done; c++) begin
                if (c > 0) next();
                load_active = ($urandom_range(0, 3) == 0);
                mem_ack = 1'b0;
                if (mem_req && !req_seen) begin
                    req_seen = 1'b1;
                    ack_dly = $urandom_range(1, 5);
                end else if (req_seen) begin
                    ack_dly--;
                    if (ack_dly == 0) begin
                        mem_ack = 1'b1;
                        req_seen = 1'b0;
                        if ($urandom_range(0, 3) != 0) resident[a[11:4]] = 1'b1;
                        else exp_miss++;
                    end
                end
                #1;
                if (dc_wenable) begin
                    writes++;
                    chk("rnd_wr_under_load", 64'(load_active), 64'd0);
                    chk("rnd_addr", 64'(dc_addr), 64'(exp_da));
                    chk("rnd_mask", 64'(dc_byte_mask), 64'(exp_mask));
                    chk("rnd_wdata", 64'(dc_wdata), 64'(exp_wd));
                end
                if (mem_req) chk("rnd_mem_addr", 64'(mem_addr), 64'(exp_line));
                if (store_success) begin
                    chk("rnd_consecutive", 64'(prev_ss), 64'd0);
                    chk("rnd_align", 64'(align_error), 64'(mis));
                    done = 1'b1;
                end
                prev_ss = store_success;
            end
            chk("rnd_done", 64'(done), 64'd1);
            chk("rnd_writes", 64'(writes), mis ? 64'd0 : 64'd1);
            chk("rnd_miss_count", 64'(miss_count), 64'(exp_miss));
            next();
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                sb_wenable = 1'b0;
                load_active = 1'(($urandom_range(0, 1)));
                #1;
                prev_ss = store_success;
                next();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
